// File: rtl/priority_req_ager.sv
// Requester-side priority ager: effective priority = base + saturating age, where age
// grows by one for every AGE_STEP_CYCLES cycles an input waits without a grant.

module priority_req_ager_lane #(
  parameter int PRIO_W = 4,
  parameter int BASE_W = 2,
  parameter int STEP   = 8,
  parameter int TMR_W  = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vld,
  input  logic              gnt,
  input  logic [BASE_W-1:0] base,
  output logic [PRIO_W-1:0] prio,
  output logic              sat
);
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [TMR_W-1:0] LAST = TMR_W'(STEP - 1);

  state_t            st;
  logic [PRIO_W-1:0] age;
  logic [TMR_W-1:0]  timer;
  logic [PRIO_W-1:0] age_inc;
  logic [PRIO_W:0]   sum;

  assign age_inc = (&age) ? age : age + PRIO_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st    <= IDLE;
      age   <= '0;
      timer <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (vld && !gnt) begin
            st <= WAIT;
            // the cycle the request first appears already counts as waiting
            if (STEP == 1) begin
              age   <= age_inc;
              timer <= '0;
            end else begin
              timer <= TMR_W'(1);
            end
          end else begin
            age   <= '0;
            timer <= '0;
          end
        end
        WAIT: begin
          if (!vld || gnt) begin
            st    <= IDLE;
            age   <= '0;
            timer <= '0;
          end else if (timer == LAST) begin
            age   <= age_inc;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          st    <= IDLE;
          age   <= '0;
          timer <= '0;
        end
      endcase
    end
  end

  assign sum  = (PRIO_W+1)'(base) + (PRIO_W+1)'(age);
  assign prio = sum[PRIO_W] ? '1 : sum[PRIO_W-1:0];
  assign sat  = (&prio) & vld;

endmodule

module priority_req_ager #(
  parameter int INPUT_NUM        = 4,
  parameter int INPUT_PRIORITY_W = 4,
  parameter int BASE_PRIORITY_W  = 2,
  parameter int AGE_STEP_CYCLES  = 8,
  parameter int AGE_STEP_CNT_W   = AGE_STEP_CYCLES > 1 ? $clog2(AGE_STEP_CYCLES) : 1
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic [INPUT_NUM-1:0]                              req_vld_i,
  input  logic [INPUT_NUM-1:0][BASE_PRIORITY_W-1:0]         req_base_priority_i,
  input  logic [INPUT_NUM-1:0]                              req_gnt_i,
  output logic [INPUT_NUM-1:0]                              req_vld_o,
  output logic [INPUT_NUM-1:0][INPUT_PRIORITY_W-1:0]        req_priority_o,
  output logic [INPUT_NUM-1:0]                              age_sat_o
);

  assign req_vld_o = req_vld_i;

  priority_req_ager_lane #(
    .PRIO_W (INPUT_PRIORITY_W),
    .BASE_W (BASE_PRIORITY_W),
    .STEP   (AGE_STEP_CYCLES),
    .TMR_W  (AGE_STEP_CNT_W)
  ) u_lane [INPUT_NUM-1:0] (
    .clk  (clk),
    .rstn (rstn),
    .vld  (req_vld_i),
    .gnt  (req_gnt_i),
    .base (req_base_priority_i),
    .prio (req_priority_o),
    .sat  (age_sat_o)
  );

  // a grant for an input that is not requesting is dropped by the lane
  always @(posedge clk) begin
    if (rstn)
      assert (~|(req_gnt_i & ~req_vld_i))
      else $warning("priority_req_ager: grant without valid ignored, gnt=%b vld=%b",
                    req_gnt_i, req_vld_i);
  end

endmodule

// File: tb/tb_priority_req_ager.sv
// Directed + randomized bench for priority_req_ager against a wait-count reference model.

module tb_priority_req_ager;
  localparam int N    = 4;
  localparam int PW   = 4;
  localparam int BW   = 2;
  localparam int STEP = 8;
  localparam int PMAX = (1 << PW) - 1;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [N-1:0]         vld, gnt;
  logic [N-1:0][BW-1:0] base;
  logic [N-1:0]         vld_o, sat_o;
  logic [N-1:0][PW-1:0] prio_o;

  int w [N];
  int checks = 0;
  int errors = 0;

  priority_req_ager #(
    .INPUT_NUM(N), .INPUT_PRIORITY_W(PW), .BASE_PRIORITY_W(BW), .AGE_STEP_CYCLES(STEP)
  ) dut (
    .clk(clk), .rstn(rstn), .req_vld_i(vld), .req_base_priority_i(base), .req_gnt_i(gnt),
    .req_vld_o(vld_o), .req_priority_o(prio_o), .age_sat_o(sat_o)
  );

  always #5 clk = ~clk;

  function automatic int exp_prio(int i);
    int a, p;
    a = w[i] / STEP;
    if (a > PMAX) a = PMAX;
    p = int'(base[i]) + a;
    if (p > PMAX) p = PMAX;
    return p;
  endfunction

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(string tag);
    for (int i = 0; i < N; i++) begin
      int p;
      p = exp_prio(i);
      chk($sformatf("%s prio[%0d]", tag, i), int'(prio_o[i]), p);
      chk($sformatf("%s vld[%0d]", tag, i), int'(vld_o[i]), int'(vld[i]));
      chk($sformatf("%s sat[%0d]", tag, i), int'(sat_o[i]), int'((p == PMAX) && vld[i]));
    end
  endtask

  // one clock: model absorbs the inputs seen at the edge, then outputs are compared
  task automatic tick(string tag);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rstn) w[i] = 0;
      else if (vld[i] && !gnt[i]) w[i] = (w[i] < 100000) ? w[i] + 1 : w[i];
      else w[i] = 0;
    end
    #1;
    check_outs(tag);
  endtask

  initial begin
    int grate;
    for (int i = 0; i < N; i++) w[i] = 0;
    rstn = 1'b0;
    vld  = 4'hF;
    gnt  = '0;
    base = {2'd3, 2'd2, 2'd1, 2'd0};
    repeat (3) tick("reset");
    chk("reset prio word", int'(prio_o), int'({4'd3, 4'd2, 4'd1, 4'd0}));

    // aging and saturation, no grants
    rstn = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      tick("aging");
      if (k == 7)   chk("age0 before first step", int'(prio_o[0]), 0);
      if (k == 8)   chk("age0 first step", int'(prio_o[0]), 1);
      if (k == 104) chk("base3 sum sat", int'(prio_o[3]), 15);
      if (k == 119) chk("sat0 not yet", int'(sat_o[0]), 0);
      if (k == 120) chk("sat0 reached", int'(sat_o[0]), 1);
      if (k == 130) chk("prio0 held", int'(prio_o[0]), 15);
    end

    // grant coincident with the age step
    rstn = 1'b0; vld = '0;
    tick("rst2");
    rstn = 1'b1; vld = 4'b0010;
    repeat (7) tick("gwait");
    gnt = 4'b0010;
    tick("gstep");
    gnt = '0;
    chk("grant beats step", int'(prio_o[1]), 1);
    repeat (8) tick("b2b");
    chk("back-to-back restarts", int'(prio_o[1]), 2);

    // withdraw and reassert
    vld = 4'b0100;
    repeat (20) tick("wwait");
    chk("withdraw age2", int'(prio_o[2]), 4);
    vld = '0;
    tick("withdraw");
    vld = 4'b0100;
    tick("reassert");
    chk("reassert base", int'(prio_o[2]), 2);

    // reset in the middle of a wait, then an illegal grant
    vld = 4'b1000;
    repeat (40) tick("mwait");
    chk("mid-wait age5", int'(prio_o[3]), 8);
    rstn = 1'b0;
    tick("mrst");
    rstn = 1'b1;
    chk("mid-wait reset", int'(prio_o[3]), 3);
    vld = '0; gnt = 4'b1000;
    tick("illegal gnt");
    gnt = '0; vld = 4'b1000;
    tick("after illegal");
    chk("illegal gnt no change", int'(prio_o[3]), 3);

    // randomized phases with sticky requests and varying grant rates
    for (int ph = 0; ph < 6; ph++) begin
      grate = (ph % 2 == 0) ? 4 : 400;
      repeat (500) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 63) == 0) vld[i] = ~vld[i];
          gnt[i] = vld[i] && ($urandom_range(0, grate - 1) == 0);
        end
        if ($urandom_range(0, 31) == 0) base = N*BW'($urandom);
        rstn = ($urandom_range(0, 999) != 0);
        tick("random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
